fetch_unit: RTL

Instruction fetch stage directly upstream of the decode controller. Holds the PC and issues in-order word requests to instruction memory over a req/gnt + rvalid interface. Buffers returned instructions in a small credit-controlled FIFO and presents them, with their PC, to decode over a valid/ready handshake. A redirect (branch/jump) flushes the buffer and discards in-flight responses before fetching resumes at the new PC.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid port, decode valid/ready port, redirect.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_inst_vld;
    logic        i_inst_rdy;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    modport master (
        output o_imem_req, o_imem_addr, o_inst, o_pc, o_inst_vld,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_rdy, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_inst, o_pc, o_inst_vld,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_rdy, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited requests to imem, small instruction buffer toward decode,
// redirect flushes the buffer and drains in-flight responses before fetching from the new PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_unit_if.master  bus
);
    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     buf_inst_q [DEPTH];
    logic [31:0]     buf_pc_q   [DEPTH];

    logic            pop;
    logic            push;
    logic            req;
    logic            grant;
    logic [CW:0]     credit_used;

    always_comb begin
        pop         = (count_q != '0) && bus.i_inst_rdy;
        // Credits cover both buffered entries and responses still owed by memory.
        credit_used = {1'b0, count_q} + {1'b0, outst_q} - (CW+1)'(pop);
        req         = !i_reset && (state_q == FETCH) && (credit_used < (CW+1)'(DEPTH));
        grant       = req && bus.i_imem_gnt;

        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        count_d   = count_q;
        outst_d   = outst_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        push      = 1'b0;

        if (bus.i_redirect) begin
            pc_d      = bus.i_redirect_pc & 32'hFFFF_FFFC;
            resp_pc_d = bus.i_redirect_pc & 32'hFFFF_FFFC;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            outst_d   = outst_q + CW'(grant) - CW'(bus.i_imem_rvalid);
            state_d   = (outst_d != '0) ? DRAIN : FETCH;
        end else if (state_q == FETCH) begin
            push = bus.i_imem_rvalid;
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            outst_d = outst_q + CW'(grant) - CW'(bus.i_imem_rvalid);
        end else begin
            // Responses to pre-redirect requests are thrown away until none remain.
            if (bus.i_imem_rvalid) begin
                outst_d = outst_q - CW'(1);
                if (outst_q == CW'(1)) begin
                    state_d = FETCH;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    buf_inst_q[gi] <= bus.i_imem_rdata;
                    buf_pc_q[gi]   <= resp_pc_q;
                end
            end
        end
    endgenerate

    always_comb begin
        bus.o_imem_req  = req;
        bus.o_imem_addr = pc_q;
        bus.o_inst_vld  = (count_q != '0);
        bus.o_inst      = NOP;
        bus.o_pc        = 32'h0000_0000;
        if (count_q != '0) begin
            bus.o_inst = buf_inst_q[rd_ptr_q];
            bus.o_pc   = buf_pc_q[rd_ptr_q];
        end
    end
endmodule
